// File: rtl/secuenciador_pkg.sv
// Shared definitions for the bit-serial comparator: FSM state encoding and
// the (m,n) inter-cell code carried between successive bit steps.
package secuenciador_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // (m,n) codes: 11 never occurs because a decided pair is frozen.
    localparam logic [1:0] MN_EQ  = 2'b00;
    localparam logic [1:0] MN_AGT = 2'b10;
    localparam logic [1:0] MN_BGT = 2'b01;

    // True once the walk has found the first differing bit.
    function automatic logic mn_decided(input logic [1:0] mn);
        return mn[1] | mn[0];
    endfunction

endpackage

// File: rtl/secuenciador_comparador_serial_celda.sv
// Single comparison cell: one step of the MSB-first comparator chain.
// A decided (m,n) pair passes through untouched; an undecided pair is
// resolved by the current bit pair (a,b).
module celda_serial (
    input  logic m,
    input  logic n,
    input  logic a,
    input  logic b,
    output logic M,
    output logic N
);

    // Hold a decided pair, otherwise let the current bits decide.
    always_comb begin
        M = 1'b0;
        N = 1'b0;
        if (m | n) begin
            M = m;
            N = n;
        end else begin
            M = a & ~b;
            N = ~a & b;
        end
    end

endmodule

// File: rtl/secuenciador_comparador_serial.sv
// Bit-serial unsigned comparator. Operands are captured on an input
// handshake, walked MSB-first through one shared celda_serial cell, and the
// result (Z = A>B, eq, lt) is presented on an output handshake.
// Optional macro SECUENCIADOR_EARLY_EXIT_EN: leave RUN as soon as the
// first differing bit has been seen instead of always walking all K bits.
module secuenciador_comparador_serial
    import secuenciador_pkg::*;
#(
    parameter int K  = 5,
    parameter int CW = (K > 1) ? $clog2(K) : 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [K-1:0] A,
    input  logic [K-1:0] B,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         Z,
    output logic         eq,
    output logic         lt
);

    state_e          state_q, state_d;
    logic [K-1:0]    a_sh_q, a_sh_d;
    logic [K-1:0]    b_sh_q, b_sh_d;
    logic [1:0]      mn_q, mn_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;
    logic            z_q, z_d;
    logic            eq_q, eq_d;
    logic            lt_q, lt_d;
    logic            cell_m_s;
    logic            cell_n_s;

    celda_serial u_celda (
        .m (mn_q[1]),
        .n (mn_q[0]),
        .a (a_sh_q[K-1]),
        .b (b_sh_q[K-1]),
        .M (cell_m_s),
        .N (cell_n_s)
    );

    // Next-state logic: operand capture, serial walk and result hand-off.
    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        mn_d    = mn_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    a_sh_d  = A;
                    b_sh_d  = B;
                    mn_d    = MN_EQ;
                    cnt_d   = CW'(K - 1);
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                mn_d   = {cell_m_s, cell_n_s};
                a_sh_d = a_sh_q << 1'b1;
                b_sh_d = b_sh_q << 1'b1;
                cnt_d  = cnt_q - CW'(1'b1);
                if (cnt_q == CW'(1'b0)) begin
                    state_d = DONE;
                end
`ifdef SECUENCIADOR_EARLY_EXIT_EN
                else if (mn_decided({cell_m_s, cell_n_s})) begin
                    state_d = DONE;
                end
`endif
                else begin
                    state_d = RUN;
                end
            end
            DONE: begin
                if (out_valid_q && out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output register inputs: valid is raised one cycle into DONE and the
    // flags are forced to zero whenever valid is low.
    always_comb begin
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_q == DONE) && !(out_valid_q && out_ready);
        z_d         = out_valid_d && (mn_q == MN_AGT);
        lt_d        = out_valid_d && (mn_q == MN_BGT);
        eq_d        = out_valid_d && (mn_q == MN_EQ);
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_sh_q      <= {K{1'b0}};
            b_sh_q      <= {K{1'b0}};
            mn_q        <= MN_EQ;
            cnt_q       <= {CW{1'b0}};
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            z_q         <= 1'b0;
            eq_q        <= 1'b0;
            lt_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_sh_q      <= a_sh_d;
            b_sh_q      <= b_sh_d;
            mn_q        <= mn_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            z_q         <= z_d;
            eq_q        <= eq_d;
            lt_q        <= lt_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign Z         = z_q;
    assign eq        = eq_q;
    assign lt        = lt_q;

endmodule

// File: tb/tb_secuenciador_comparador_serial.sv
// Bench for secuenciador_comparador_serial with K=5, K=1 and K=8 instances.
// A scoreboard holds expected flags and the cycle the result must appear.
`timescale 1ns/1ps
module tb_secuenciador_comparador_serial;

    typedef struct {
        logic [2:0] flags;
        int         due;
    } sb_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid_v  [3];
    logic       out_ready_v [3];
    logic [7:0] a_v         [3];
    logic [7:0] b_v         [3];
    logic       in_ready_v  [3];
    logic       out_valid_v [3];
    logic       z_v         [3];
    logic       eq_v        [3];
    logic       lt_v        [3];

    int  cyc    = 0;
    int  checks = 0;
    int  errors = 0;
    sb_t sb[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    secuenciador_comparador_serial #(.K(5)) dut5 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
        .A(a_v[0][4:0]), .B(b_v[0][4:0]), .out_valid(out_valid_v[0]),
        .out_ready(out_ready_v[0]), .Z(z_v[0]), .eq(eq_v[0]), .lt(lt_v[0]));

    secuenciador_comparador_serial #(.K(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
        .A(a_v[1][0:0]), .B(b_v[1][0:0]), .out_valid(out_valid_v[1]),
        .out_ready(out_ready_v[1]), .Z(z_v[1]), .eq(eq_v[1]), .lt(lt_v[1]));

    secuenciador_comparador_serial #(.K(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
        .A(a_v[2][7:0]), .B(b_v[2][7:0]), .out_valid(out_valid_v[2]),
        .out_ready(out_ready_v[2]), .Z(z_v[2]), .eq(eq_v[2]), .lt(lt_v[2]));

    function automatic int kof(input int idx);
        case (idx)
            0:       return 5;
            1:       return 1;
            default: return 8;
        endcase
    endfunction

    function automatic logic [2:0] ref_flags(input logic [7:0] a, input logic [7:0] b);
        return {a > b, a == b, a < b};
    endfunction

    // Cycles from the handshake edge until out_valid is visible.
    function automatic int ref_lat(input logic [7:0] a, input logic [7:0] b, input int k);
        int lat;
        lat = k + 1;
`ifdef SECUENCIADOR_EARLY_EXIT_EN
        for (int i = k - 1; i >= 0; i--) begin
            if (a[i] != b[i]) begin
                lat = (k - 1 - i) + 2;
                break;
            end
        end
`endif
        return lat;
    endfunction

    // Compare one instance against the model, update the scoreboard, advance a cycle.
    task automatic tick(input int idx, output bit hs);
        int         k;
        logic [7:0] mask, a, b;
        logic       exp_valid, exp_rdy;
        logic [2:0] exp_fl, got_fl;
        sb_t        e;
        k         = kof(idx);
        mask      = (8'd1 << k) - 8'd1;
        a         = a_v[idx] & mask;
        b         = b_v[idx] & mask;
        exp_valid = (sb.size() > 0) && (cyc >= sb[0].due);
        exp_fl    = exp_valid ? sb[0].flags : 3'b000;
        exp_rdy   = (sb.size() == 0);
        got_fl    = {z_v[idx], eq_v[idx], lt_v[idx]};
        checks++;
        if (out_valid_v[idx] !== exp_valid) begin
            errors++;
            $display("FAIL out_valid k=%0d cyc=%0d got %b exp %b", k, cyc, out_valid_v[idx], exp_valid);
        end
        checks++;
        if (got_fl !== exp_fl) begin
            errors++;
            $display("FAIL flags{Z,eq,lt} k=%0d cyc=%0d got %b exp %b", k, cyc, got_fl, exp_fl);
        end
        checks++;
        if (in_ready_v[idx] !== exp_rdy) begin
            errors++;
            $display("FAIL in_ready k=%0d cyc=%0d got %b exp %b", k, cyc, in_ready_v[idx], exp_rdy);
        end
        hs = in_valid_v[idx] && exp_rdy;
        if (exp_valid && out_ready_v[idx]) void'(sb.pop_front());
        if (hs) begin
            e.flags = ref_flags(a, b);
            e.due   = cyc + 1 + ref_lat(a, b, k);
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int idx, input logic [7:0] a, input logic [7:0] b);
        bit hs;
        int n;
        hs = 1'b0;
        n  = 0;
        a_v[idx]        = a;
        b_v[idx]        = b;
        in_valid_v[idx] = 1'b1;
        while (!hs && n < 40) begin
            tick(idx, hs);
            n++;
        end
        in_valid_v[idx] = 1'b0;
        checks++;
        if (!hs) begin
            errors++;
            $display("FAIL send_timeout k=%0d got no handshake exp handshake", kof(idx));
        end
    endtask

    task automatic drain(input int idx);
        bit hs;
        int n;
        n = 0;
        while (sb.size() > 0 && n < 200) begin
            tick(idx, hs);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout k=%0d got %0d pending exp 0", kof(idx), sb.size());
        end
        tick(idx, hs);
    endtask

    task automatic check_zero_outputs(input string name);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({in_ready_v[i], out_valid_v[i], z_v[i], eq_v[i], lt_v[i]} !== 5'b00000) begin
                errors++;
                $display("FAIL %s k=%0d got %b exp 00000", name, kof(i),
                         {in_ready_v[i], out_valid_v[i], z_v[i], eq_v[i], lt_v[i]});
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid_v[i]  = 1'b0;
            out_ready_v[i] = 1'b1;
            a_v[i]         = 8'd0;
            b_v[i]         = 8'd0;
        end
        #2;
        check_zero_outputs("reset_outputs");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check_zero_outputs("after_release");
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (in_ready_v[i] !== 1'b1) begin
                errors++;
                $display("FAIL in_ready_rise k=%0d got %b exp 1", kof(i), in_ready_v[i]);
            end
        end
    endtask

    task automatic test_gt();
        out_ready_v[0] = 1'b1;
        send(0, 8'b10110, 8'b10011);
        drain(0);
    endtask

    task automatic test_equal();
        send(0, 8'b01101, 8'b01101);
        drain(0);
    endtask

    task automatic test_backpressure();
        bit hs;
        int n;
        n = 0;
        out_ready_v[0] = 1'b0;
        send(0, 8'd0, 8'd31);
        while (out_valid_v[0] !== 1'b1 && n < 20) begin
            tick(0, hs);
            n++;
        end
        repeat (3) tick(0, hs);
        out_ready_v[0] = 1'b1;
        drain(0);
    endtask

    task automatic test_reset_mid_run();
        bit hs;
        send(0, 8'($urandom), 8'($urandom));
        tick(0, hs);
        tick(0, hs);
        rst_n = 1'b0;
        #1;
        check_zero_outputs("reset_mid_run");
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check_zero_outputs("mid_run_release");
        @(posedge clk);
        #1;
        repeat (8) tick(0, hs);
        send(0, 8'b00111, 8'b00110);
        drain(0);
    endtask

    task automatic test_operand_change();
        bit hs;
        int n;
        n = 0;
        send(0, 8'b01000, 8'b01001);
        while (sb.size() > 0 && n < 40) begin
            a_v[0] = 8'($urandom);
            b_v[0] = 8'($urandom);
            tick(0, hs);
            n++;
        end
        drain(0);
    endtask

    task automatic test_back_to_back(input int idx);
        bit hs;
        int sent, n;
        sent = 0;
        n    = 0;
        out_ready_v[idx] = 1'b1;
        a_v[idx]         = 8'($urandom);
        b_v[idx]         = 8'($urandom);
        in_valid_v[idx]  = 1'b1;
        while (sent < 20 && n < 1000) begin
            tick(idx, hs);
            n++;
            if (hs) begin
                sent++;
                a_v[idx] = 8'($urandom);
                b_v[idx] = 8'($urandom);
            end
        end
        in_valid_v[idx] = 1'b0;
        drain(idx);
    endtask

    initial begin
        test_reset();
        test_gt();
        test_equal();
        test_backpressure();
        test_reset_mid_run();
        test_operand_change();
        test_back_to_back(1);
        test_back_to_back(2);
        test_back_to_back(0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
